// File: rtl/core_wb_arbiter_pkg.sv
// rtl/core_wb_arbiter_pkg.sv - shared core widths and requester constants for the write-back arbiter
// Optional MDU requester: CORE_WB_MDU_EN.
`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif
`ifndef CORE_RFIDX_WIDTH
`define CORE_RFIDX_WIDTH 5
`endif

package core_wb_arbiter_pkg;

    localparam int XLEN    = `CORE_XLEN;
    localparam int RFIDX_W = `CORE_RFIDX_WIDTH;

    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
`ifdef CORE_WB_MDU_EN
    localparam int WB_MDU = 2;
    localparam int WB_N   = 3;
`else
    localparam int WB_N   = 2;
`endif

    localparam int RR_W = (WB_N > 2) ? 2 : 1;

    // Pointer advances to the requester after the winner, wrapping at WB_N.
    function automatic logic [RR_W-1:0] rr_next(input logic [RR_W-1:0] g);
        return (g == RR_W'(WB_N - 1)) ? '0 : g + 1'b1;
    endfunction

endpackage

// File: rtl/core_gnrl_dffs.sv
// rtl/core_gnrl_dffs.sv - generic load-enable flop cell with synchronous active-high reset to zero
module core_gnrl_dfflr #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            qout <= '0;
        end else if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/core_rr_arb.sv
// rtl/core_rr_arb.sv - round-robin selector: request vector and start pointer in, one-hot grant out
module core_rr_arb #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    localparam logic [PW:0] NV = (PW + 1)'(N);

    logic [PW:0]   sum;
    logic [PW-1:0] k;

    // Walk the search order backwards so the earliest valid requester is written last and wins.
    always_comb begin
        gnt = '0;
        sum = '0;
        k   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (PW + 1)'(i);
            if (sum >= NV) begin
                sum = sum - NV;
            end
            k = sum[PW-1:0];
            if (req[k]) begin
                gnt    = '0;
                gnt[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_wb_arbiter.sv
// rtl/core_wb_arbiter.sv - round-robin arbiter for the single register-file write port
// Optional MDU requester: CORE_WB_MDU_EN.
module core_wb_arbiter
    import core_wb_arbiter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alu_wb_valid,
    output logic               alu_wb_ready,
    input  logic [RFIDX_W-1:0] alu_wb_idx,
    input  logic [XLEN-1:0]    alu_wb_dat,
    input  logic               lsu_wb_valid,
    output logic               lsu_wb_ready,
    input  logic [RFIDX_W-1:0] lsu_wb_idx,
    input  logic [XLEN-1:0]    lsu_wb_dat,
`ifdef CORE_WB_MDU_EN
    input  logic               mdu_wb_valid,
    output logic               mdu_wb_ready,
    input  logic [RFIDX_W-1:0] mdu_wb_idx,
    input  logic [XLEN-1:0]    mdu_wb_dat,
`endif
    output logic               wb_dest_wen,
    output logic [RFIDX_W-1:0] wb_dest_idx,
    output logic [XLEN-1:0]    wb_dest_dat,
    output logic [CNT_W-1:0]   conflict_cnt
);

    logic [WB_N-1:0]    req_vld;
    logic [WB_N-1:0]    req_act;
    logic [WB_N-1:0]    gnt;
    logic [RFIDX_W-1:0] req_idx [WB_N];
    logic [XLEN-1:0]    req_dat [WB_N];
    logic [RR_W-1:0]    rr_ptr;
    logic [RR_W-1:0]    gnt_id;
    logic [RFIDX_W-1:0] sel_idx;
    logic [XLEN-1:0]    sel_dat;
    logic [1:0]         nvld;
    logic               any_gnt;
    logic               multi_vld;
    logic               wen_nxt;
    logic               cnt_ld;

    assign req_vld[WB_ALU] = alu_wb_valid;
    assign req_idx[WB_ALU] = alu_wb_idx;
    assign req_dat[WB_ALU] = alu_wb_dat;
    assign req_vld[WB_LSU] = lsu_wb_valid;
    assign req_idx[WB_LSU] = lsu_wb_idx;
    assign req_dat[WB_LSU] = lsu_wb_dat;
    assign alu_wb_ready    = gnt[WB_ALU];
    assign lsu_wb_ready    = gnt[WB_LSU];
`ifdef CORE_WB_MDU_EN
    assign req_vld[WB_MDU] = mdu_wb_valid;
    assign req_idx[WB_MDU] = mdu_wb_idx;
    assign req_dat[WB_MDU] = mdu_wb_dat;
    assign mdu_wb_ready    = gnt[WB_MDU];
`endif

    // Masking the requests in reset keeps every ready low and the pointer frozen.
    assign req_act = rst ? '0 : req_vld;

    core_rr_arb #(
        .N  (WB_N),
        .PW (RR_W)
    ) u_rr_arb (
        .req (req_act),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    always_comb begin
        sel_idx = '0;
        sel_dat = '0;
        gnt_id  = '0;
        nvld    = '0;
        for (int i = 0; i < WB_N; i++) begin
            nvld = nvld + {1'b0, req_vld[i]};
            if (gnt[i]) begin
                sel_idx = sel_idx | req_idx[i];
                sel_dat = sel_dat | req_dat[i];
                gnt_id  = RR_W'(i);
            end
        end
    end

    assign any_gnt   = |gnt;
    assign multi_vld = (nvld >= 2'd2);
    // x0 is hard-wired zero, so its write is accepted but never enabled.
    assign wen_nxt   = any_gnt && (sel_idx != '0);
    assign cnt_ld    = multi_vld && (conflict_cnt != '1);

    core_gnrl_dfflr #(.DW(RR_W)) u_rr_ptr (
        .clk  (clk),
        .rst  (rst),
        .lden (any_gnt),
        .dnxt (rr_next(gnt_id)),
        .qout (rr_ptr)
    );

    core_gnrl_dfflr #(.DW(1)) u_wen (
        .clk  (clk),
        .rst  (rst),
        .lden (1'b1),
        .dnxt (wen_nxt),
        .qout (wb_dest_wen)
    );

    core_gnrl_dfflr #(.DW(RFIDX_W)) u_idx (
        .clk  (clk),
        .rst  (rst),
        .lden (any_gnt),
        .dnxt (sel_idx),
        .qout (wb_dest_idx)
    );

    core_gnrl_dfflr #(.DW(XLEN)) u_dat (
        .clk  (clk),
        .rst  (rst),
        .lden (any_gnt),
        .dnxt (sel_dat),
        .qout (wb_dest_dat)
    );

    core_gnrl_dfflr #(.DW(CNT_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .lden (cnt_ld),
        .dnxt (conflict_cnt + CNT_W'(1)),
        .qout (conflict_cnt)
    );

endmodule
